// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port fixed-latency memory between fetch (read-only) and data (read/write) requesters.
// Build with MEM_ARB_FAIRNESS_EN defined to bound consecutive data grants while a fetch waits.
module mem_port_arbiter #(
   parameter int MEM_LATENCY = 1,
   parameter int STREAK_MAX  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_stall,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_stall,
   output logic        m_en,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

   if (MEM_LATENCY < 1 || MEM_LATENCY > 4 || STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_param_check
      $error("mem_port_arbiter: parameter out of range");
   end

   state_t      state_q, state_d;
   logic        own_if_q, own_if_d;
   logic        own_d_q, own_d_d;
   logic        we_q, we_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] m_addr_q, m_addr_d;
   logic [31:0] m_wdata_q, m_wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        fetch_win;
`ifdef MEM_ARB_FAIRNESS_EN
   logic [3:0]  streak_q, streak_d;
`endif

   always_comb begin
      state_d    = state_q;
      own_if_d   = own_if_q;
      own_d_d    = own_d_q;
      we_d       = we_q;
      cnt_d      = cnt_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      fetch_win  = 1'b0;
      if_gnt     = 1'b0;
      d_gnt      = 1'b0;
      if_rvalid  = 1'b0;
      d_rvalid   = 1'b0;
      m_en       = 1'b0;
      m_we       = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
      streak_d   = streak_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef MEM_ARB_FAIRNESS_EN
            fetch_win = if_req & (~d_req | (streak_q == 4'(STREAK_MAX)));
            // Streak only counts data grants that actually made a fetch wait.
            if (!if_req || fetch_win)
               streak_d = 4'd0;
            else if (d_req && streak_q != 4'(STREAK_MAX))
               streak_d = streak_q + 4'd1;
`else
            fetch_win = if_req & ~d_req;
`endif
            if (fetch_win) begin
               own_if_d = 1'b1;
               own_d_d  = 1'b0;
               we_d     = 1'b0;
               m_addr_d = if_addr;
               state_d  = ACCESS;
            end else if (d_req) begin
               own_if_d  = 1'b0;
               own_d_d   = 1'b1;
               we_d      = d_we;
               m_addr_d  = d_addr;
               m_wdata_d = d_wdata;
               state_d   = ACCESS;
            end
         end
         ACCESS: begin
            m_en    = 1'b1;
            m_we    = we_q;
            if_gnt  = own_if_q;
            d_gnt   = own_d_q;
            cnt_d   = 2'(MEM_LATENCY - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == 2'd0) begin
               if_rvalid = own_if_q;
               d_rvalid  = own_d_q;
               if (own_if_q)
                  if_rdata_d = m_rdata;
               if (own_d_q && !we_q)
                  d_rdata_d = m_rdata;
               own_if_d = 1'b0;
               own_d_d  = 1'b0;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         own_if_q   <= 1'b0;
         own_d_q    <= 1'b0;
         we_q       <= 1'b0;
         cnt_q      <= 2'd0;
         m_addr_q   <= 32'd0;
         m_wdata_q  <= 32'd0;
         if_rdata_q <= 32'd0;
         d_rdata_q  <= 32'd0;
`ifdef MEM_ARB_FAIRNESS_EN
         streak_q   <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         own_if_q   <= own_if_d;
         own_d_q    <= own_d_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_FAIRNESS_EN
         streak_q   <= streak_d;
`endif
      end
   end

   // Read data is forwarded in its rvalid cycle and held in the register afterwards.
   assign if_rdata = if_rdata_d;
   assign d_rdata  = d_rdata_d;
   assign if_stall = if_req & ~if_rvalid;
   assign d_stall  = d_req & ~d_rvalid;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LATENCY=1 instance with a memory model,
// plus a MEM_LATENCY=3 instance for latency and mid-access reset.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, if_req, if_gnt, if_rvalid, if_stall, d_req, d_we, d_gnt, d_rvalid, d_stall;
   logic        m_en, m_we, busy;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;

   logic        rst3, if_req3, if_gnt3, if_rvalid3, if_stall3, d_req3, d_we3, d_gnt3, d_rvalid3, d_stall3;
   logic        m_en3, m_we3, busy3;
   logic [31:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3, m_addr3, m_wdata3, m_rdata3;

   mem_port_arbiter #(.MEM_LATENCY(1), .STREAK_MAX(4)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_stall(d_stall),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .busy(busy)
   );

   mem_port_arbiter #(.MEM_LATENCY(3), .STREAK_MAX(4)) u_dut3 (
      .clk(clk), .rst(rst3),
      .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3),
      .if_rdata(if_rdata3), .if_stall(if_stall3),
      .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_gnt(d_gnt3),
      .d_rvalid(d_rvalid3), .d_rdata(d_rdata3), .d_stall(d_stall3),
      .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3),
      .busy(busy3)
   );

   // Latency-1 memory macro model.
   logic [31:0] mem [0:4095];
   logic [31:0] m_rdata_r;
   assign m_rdata = m_rdata_r;
   always @(posedge clk) begin
      if (m_en) begin
         if (m_we)
            mem[m_addr[13:2]] <= m_wdata;
         else
            m_rdata_r <= mem[m_addr[13:2]];
      end
   end

   // Latency-3 memory: returns address ^ 0xA5A50000, never reset so stale data can arrive.
   logic [31:0] p3 [0:2];
   assign m_rdata3 = p3[2];
   always @(posedge clk) begin
      p3[0] <= m_en3 ? (m_addr3 ^ 32'hA5A50000) : 32'h0;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   typedef struct {
      bit          is_d;
      logic [31:0] data;
      string       name;
   } exp_t;
   exp_t sb[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input bit is_d, input logic [31:0] data, input string name);
      exp_t e;
      e.is_d = is_d;
      e.data = data;
      e.name = name;
      sb.push_back(e);
   endtask

   // Monitor: pops an expected response whenever either requester sees rvalid.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (if_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_owner"}, {31'd0, d_rvalid}, {31'd0, e.is_d});
               chk({e.name, "_rdata"}, e.is_d ? d_rdata : if_rdata, e.data);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // One isolated access on the latency-1 instance with exact-cycle checks.
   task automatic single(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] expv, input string name);
      push(is_d, expv, name);
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      #1 chk({name, "_stall"}, {31'd0, is_d ? d_stall : if_stall}, 32'd1);
      @(negedge clk);
      chk({name, "_gnt"}, {31'd0, is_d ? d_gnt : if_gnt}, 32'd1);
      chk({name, "_m_en"}, {31'd0, m_en}, 32'd1);
      chk({name, "_m_addr"}, m_addr, addr);
      chk({name, "_m_we"}, {31'd0, m_we}, {31'd0, we});
      chk({name, "_busy_hi"}, {31'd0, busy}, 32'd1);
      if (we) chk({name, "_m_wdata"}, m_wdata, wdata);
      d_req = 1'b0; if_req = 1'b0;
      @(negedge clk);
      chk({name, "_rvalid"}, {31'd0, is_d ? d_rvalid : if_rvalid}, 32'd1);
      chk({name, "_m_en_lo"}, {31'd0, m_en}, 32'd0);
      @(negedge clk);
      chk({name, "_busy_lo"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int dg;
      int lat;
      int en_cnt;
      int rv_cnt;
      bit got;
      logic [9:0] order;
      int ng;

      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem[32'h100 >> 2]             = 32'h00000013;
      mem[32'h104 >> 2]             = 32'h00A00093;
      mem[(32'h3000 >> 2) & 12'hFFF] = 32'hCAFEF00D;

      rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
      d_addr = 32'h0; d_wdata = 32'h0;
      rst3 = 1'b1; if_req3 = 1'b0; if_addr3 = 32'h0; d_req3 = 1'b0; d_we3 = 1'b0;
      d_addr3 = 32'h0; d_wdata3 = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_ctrl", {23'd0, if_gnt, if_rvalid, if_stall, d_gnt, d_rvalid, d_stall, m_en, m_we, busy}, 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      chk("rst_m_wdata", m_wdata, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      rst = 1'b0; rst3 = 1'b0;
      @(negedge clk);

      single(1'b0, 1'b0, 32'h100, 32'h0, 32'h00000013, "fetch100");
      single(1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 32'h0, "wr2004");
      chk("wr_d_rdata_hold", d_rdata, 32'h0);
      single(1'b1, 1'b0, 32'h2004, 32'h0, 32'hDEADBEEF, "rd2004");
      chk("if_rdata_hold", if_rdata, 32'h00000013);

      // Both requesters at once: data keeps winning while d_req is held.
      push(1'b1, 32'hCAFEF00D, "simul_d0");
      push(1'b1, 32'hCAFEF00D, "simul_d1");
      push(1'b0, 32'h00A00093, "simul_i");
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
      if_req = 1'b1; if_addr = 32'h104;
      dg = 0; got = 1'b0;
      for (int c = 0; c < 30 && !got; c++) begin
         @(negedge clk);
         if (!if_rvalid) chk("simul_if_stall", {31'd0, if_stall}, 32'd1);
         if (d_gnt) begin
            dg++;
            if (dg == 2) d_req = 1'b0;
         end
         if (if_gnt) begin
            got = 1'b1;
            chk("simul_dgnt_before_ignt", dg, 32'd2);
            if_req = 1'b0;
         end
      end
      chk("simul_ignt_seen", {31'd0, got}, 32'd1);
      repeat (4) @(negedge clk);

`ifdef MEM_ARB_FAIRNESS_EN
      for (int k = 0; k < 10; k++)
         push(k == 4 || k == 9 ? 1'b0 : 1'b1, k == 4 || k == 9 ? 32'h00A00093 : 32'hCAFEF00D, "fair");
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
      if_req = 1'b1; if_addr = 32'h104;
      order = 10'd0; ng = 0;
      for (int c = 0; c < 200 && ng < 10; c++) begin
         @(negedge clk);
         if (if_gnt || d_gnt) begin
            order[ng] = if_gnt;
            ng++;
            if (ng == 10) begin
               d_req = 1'b0; if_req = 1'b0;
            end
         end
      end
      chk("fair_order", {22'd0, order}, {22'd0, 10'b1000010000});
      repeat (4) @(negedge clk);
`else
      order = 10'd0; ng = 0;
`endif

      // Latency-3 instance: fetch timing.
      if_req3 = 1'b1; if_addr3 = 32'h40;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         if (if_gnt3) got = 1'b1;
      end
      chk("l3_gnt_seen", {31'd0, got}, 32'd1);
      chk("l3_m_addr", m_addr3, 32'h40);
      en_cnt = m_en3 ? 1 : 0;
      if_req3 = 1'b0;
      lat = 0; got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         lat++;
         if (m_en3) en_cnt++;
         if (if_rvalid3) got = 1'b1;
      end
      chk("l3_rvalid_lat", lat, 32'd3);
      chk("l3_m_en_cycles", en_cnt, 32'd1);
      chk("l3_rdata", if_rdata3, 32'hA5A50040);
      @(negedge clk);

      // Reset during WAIT: response must be abandoned.
      d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h80;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         if (d_gnt3) got = 1'b1;
      end
      chk("rst3_gnt_seen", {31'd0, got}, 32'd1);
      d_req3 = 1'b0;
      @(negedge clk);
      rst3 = 1'b1;
      #1;
      chk("rst3_ctrl", {26'd0, d_rvalid3, d_gnt3, if_rvalid3, m_en3, m_we3, busy3}, 32'd0);
      chk("rst3_m_addr", m_addr3, 32'd0);
      chk("rst3_if_rdata", if_rdata3, 32'd0);
      chk("rst3_d_rdata", d_rdata3, 32'd0);
      @(negedge clk);
      rst3 = 1'b0;
      rv_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (d_rvalid3 || if_rvalid3) rv_cnt++;
      end
      chk("rst3_no_rvalid", rv_cnt, 32'd0);

      d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h84;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         if (d_gnt3) got = 1'b1;
      end
      chk("post_rst_gnt_seen", {31'd0, got}, 32'd1);
      d_req3 = 1'b0;
      lat = 0; got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         lat++;
         if (d_rvalid3) got = 1'b1;
      end
      chk("post_rst_lat", lat, 32'd3);
      chk("post_rst_rdata", d_rdata3, 32'hA5A50084);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
